axi_eth_rx_filter: RTL

- Parametrised, single-clock successor of the 10GbE RX ingress path.
- Store-and-forward frame filter between the MAC RX AXI-Stream and the S2MM DMA streams.
- Buffers each frame and commits it only if it is error-free, in length range and fully stored. Otherwise it rewinds the write pointer, so no partial or bad data ever reaches rxd.
- Emits one status word per committed frame on rxs and keeps saturating drop statistics.

---
 rtl/axi_eth_pkg.sv | 36 +++
 rtl/axi_eth_rx_sdpram.sv | 27 ++
 rtl/axi_eth_rx_filter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_eth_pkg.sv
// Shared types and helpers for the Ethernet RX store-and-forward filter.
package axi_eth_pkg;

  // Status word field positions
  localparam int unsigned LEN_LO = 0;
  localparam int unsigned LEN_HI = 15;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_ERR,
    CAUSE_LEN,
    CAUSE_OVF
  } drop_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DROP
  } wr_state_e;

  // Byte count of a keep vector (up to 32 lanes)
  function automatic logic [5:0] keep_count(input logic [31:0] keep);
    logic [5:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      cnt = cnt + 6'(keep[i]);
    end
    return cnt;
  endfunction

  // Increment that holds at all-ones
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axi_eth_rx_sdpram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module axi_eth_rx_sdpram #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; output holds while re is low
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_eth_rx_filter.sv
// Store-and-forward RX frame filter: buffers each MAC frame, commits only
// error-free, in-range, fully stored frames and reports one status per frame.
module axi_eth_rx_filter
  import axi_eth_pkg::*;
#(
  parameter  int unsigned C_DATA_WIDTH     = 64,
  parameter  int unsigned C_DEPTH_LOG2     = 9,
  parameter  int unsigned C_STS_DEPTH_LOG2 = 4,
  parameter  int unsigned C_MIN_LEN        = 64,
  parameter  int unsigned C_MAX_LEN        = 1518,
  localparam int unsigned C_KEEP_WIDTH     = C_DATA_WIDTH / 8
) (
  input  logic                    rx_clk,
  input  logic                    rx_reset,
  input  logic [C_DATA_WIDTH-1:0] rx_axis_mac_tdata,
  input  logic [C_KEEP_WIDTH-1:0] rx_axis_mac_tkeep,
  input  logic                    rx_axis_mac_tlast,
  input  logic                    rx_axis_mac_tuser,
  input  logic                    rx_axis_mac_tvalid,
  output logic [C_DATA_WIDTH-1:0] rxd_tdata,
  output logic [C_KEEP_WIDTH-1:0] rxd_tkeep,
  output logic                    rxd_tlast,
  output logic                    rxd_tvalid,
  input  logic                    rxd_tready,
  output logic [31:0]             rxs_tdata,
  output logic [3:0]              rxs_tkeep,
  output logic                    rxs_tlast,
  output logic                    rxs_tvalid,
  input  logic                    rxs_tready,
  output logic [31:0]             stat_ok,
  output logic [31:0]             stat_drop_err,
  output logic [31:0]             stat_drop_ovf,
  output logic [31:0]             stat_drop_len
);

  localparam int unsigned PW    = C_DEPTH_LOG2 + 1;
  localparam int unsigned SPW   = C_STS_DEPTH_LOG2 + 1;
  localparam int unsigned EW    = C_DATA_WIDTH + C_KEEP_WIDTH + 1;
  localparam int unsigned STS_W = LEN_HI - LEN_LO + 1;

  localparam logic [PW-1:0]  DEPTH     = {1'b1, {C_DEPTH_LOG2{1'b0}}};
  localparam logic [SPW-1:0] STS_DEPTH = {1'b1, {C_STS_DEPTH_LOG2{1'b0}}};
  localparam logic [15:0]    MIN_LEN   = 16'(C_MIN_LEN);
  localparam logic [15:0]    MAX_LEN   = 16'(C_MAX_LEN);
  localparam logic [15:0]    LEN_SAT   = 16'(C_MAX_LEN + 1);

  wr_state_e   state, state_n;
  drop_cause_e cause, cause_n, drop_now;

  logic [PW-1:0]  wr_ptr, wr_cmt, rd_ptr;
  logic [SPW-1:0] sts_wr, sts_rd;
  logic [15:0]    len, len_n;
  logic [16:0]    len_sum;
  logic [5:0]     beat_bytes;
  logic           full, sts_full, buf_we, commit;

  logic [EW-1:0]    buf_rdata, out_q, sp_q;
  logic [STS_W-1:0] sts_rdata;
  logic             rd_re, rd_inflight, out_vld, sp_vld, pop, sts_re;
  logic [1:0]       occ;

  // Running frame length, saturating just past the maximum
  always_comb begin
    beat_bytes = keep_count(32'(rx_axis_mac_tkeep));
    len_sum    = {1'b0, (state == ST_IDLE) ? 16'd0 : len} + 17'(beat_bytes);
    len_n      = (len_sum > 17'(LEN_SAT)) ? LEN_SAT : len_sum[15:0];
    full       = (wr_ptr - rd_ptr) == DEPTH;
    sts_full   = (sts_wr - sts_rd) == STS_DEPTH;
  end

  // Write FSM next state, buffer write enable and commit/drop decision
  always_comb begin
    state_n  = state;
    cause_n  = cause;
    buf_we   = 1'b0;
    commit   = 1'b0;
    drop_now = CAUSE_NONE;
    case (state)
      ST_IDLE, ST_RECV: begin
        if (rx_axis_mac_tvalid) begin
          buf_we = !full;
          if (rx_axis_mac_tlast) begin
            state_n = ST_IDLE;
            if (rx_axis_mac_tuser)                          drop_now = CAUSE_ERR;
            else if (len_n < MIN_LEN || len_n > MAX_LEN)    drop_now = CAUSE_LEN;
            else if (sts_full || full)                      drop_now = CAUSE_OVF;
            else                                            commit   = 1'b1;
          end else if (len_n > MAX_LEN) begin
            state_n = ST_DROP;
            cause_n = CAUSE_LEN;
          end else if (full) begin
            state_n = ST_DROP;
            cause_n = CAUSE_OVF;
          end else begin
            state_n = ST_RECV;
          end
        end
      end
      ST_DROP: begin
        if (rx_axis_mac_tvalid && rx_axis_mac_tlast) begin
          state_n  = ST_IDLE;
          drop_now = cause;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Write-side state: FSM, length, speculative and committed pointers.
  // Commit updates wr_cmt at the tlast edge, so it is visible one cycle later.
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state  <= ST_IDLE;
      cause  <= CAUSE_NONE;
      len    <= '0;
      wr_ptr <= '0;
      wr_cmt <= '0;
    end else begin
      state <= state_n;
      cause <= cause_n;
      if (rx_axis_mac_tvalid) len <= len_n;
      if (drop_now != CAUSE_NONE) wr_ptr <= wr_cmt;
      else if (buf_we)            wr_ptr <= wr_ptr + 1'b1;
      if (commit) wr_cmt <= wr_ptr + 1'b1;
    end
  end

  // Saturating frame statistics; each frame counted exactly once
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      stat_ok       <= '0;
      stat_drop_err <= '0;
      stat_drop_ovf <= '0;
      stat_drop_len <= '0;
    end else begin
      if (commit) stat_ok <= sat_inc(stat_ok);
      case (drop_now)
        CAUSE_ERR: stat_drop_err <= sat_inc(stat_drop_err);
        CAUSE_LEN: stat_drop_len <= sat_inc(stat_drop_len);
        CAUSE_OVF: stat_drop_ovf <= sat_inc(stat_drop_ovf);
        default: ;
      endcase
    end
  end

  axi_eth_rx_sdpram #(
    .WIDTH      (EW),
    .DEPTH_LOG2 (C_DEPTH_LOG2)
  ) u_data_ram (
    .clk   (rx_clk),
    .we    (buf_we),
    .waddr (wr_ptr[C_DEPTH_LOG2-1:0]),
    .wdata ({rx_axis_mac_tlast, rx_axis_mac_tkeep, rx_axis_mac_tdata}),
    .re    (rd_re),
    .raddr (rd_ptr[C_DEPTH_LOG2-1:0]),
    .rdata (buf_rdata)
  );

  // Read issue: only committed beats, and only if the skid can absorb the result
  always_comb begin
    pop   = out_vld && rxd_tready;
    occ   = 2'(out_vld) + 2'(sp_vld) + 2'(rd_inflight);
    rd_re = (rd_ptr != wr_cmt) && (occ < (2'd2 + 2'(pop)));
  end

  // Read pointer and 2-entry skid occupancy (out_q is the head / output register)
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
      out_vld     <= 1'b0;
      sp_vld      <= 1'b0;
    end else begin
      rd_inflight <= rd_re;
      if (rd_re) rd_ptr <= rd_ptr + 1'b1;
      if (!out_vld || pop) begin
        if (sp_vld) begin
          out_vld <= 1'b1;
          sp_vld  <= rd_inflight;
        end else begin
          out_vld <= rd_inflight;
        end
      end else if (rd_inflight) begin
        sp_vld <= 1'b1;
      end
    end
  end

  // Skid data path, mirroring the occupancy moves above
  always_ff @(posedge rx_clk) begin
    if (!out_vld || pop) begin
      if (sp_vld) begin
        out_q <= sp_q;
        sp_q  <= buf_rdata;
      end else begin
        out_q <= buf_rdata;
      end
    end else if (rd_inflight) begin
      sp_q <= buf_rdata;
    end
  end

  assign {rxd_tlast, rxd_tkeep, rxd_tdata} = out_q;
  assign rxd_tvalid = out_vld;

  axi_eth_rx_sdpram #(
    .WIDTH      (STS_W),
    .DEPTH_LOG2 (C_STS_DEPTH_LOG2)
  ) u_sts_ram (
    .clk   (rx_clk),
    .we    (commit),
    .waddr (sts_wr[C_STS_DEPTH_LOG2-1:0]),
    .wdata (len_n),
    .re    (sts_re),
    .raddr (sts_rd[C_STS_DEPTH_LOG2-1:0]),
    .rdata (sts_rdata)
  );

  assign sts_re = (sts_rd != sts_wr) && (!rxs_tvalid || rxs_tready);

  // Status FIFO pointers; the RAM read register doubles as the rxs output stage
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      sts_wr     <= '0;
      sts_rd     <= '0;
      rxs_tvalid <= 1'b0;
    end else begin
      if (commit) sts_wr <= sts_wr + 1'b1;
      if (sts_re) sts_rd <= sts_rd + 1'b1;
      if (sts_re)          rxs_tvalid <= 1'b1;
      else if (rxs_tready) rxs_tvalid <= 1'b0;
    end
  end

  // Status word assembly
  always_comb begin
    rxs_tdata               = '0;
    rxs_tdata[LEN_HI:LEN_LO] = sts_rdata;
  end

  assign rxs_tkeep = 4'hF;
  assign rxs_tlast = 1'b1;

endmodule
